// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data-memory responder with LAT wait states; DMEM_STATS_EN adds read/write counters
module dmem_responder #(
    parameter int LAT = 2,
    parameter int AW  = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        derr,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic          r_mis;
    logic [AW-1:0] r_word;
    logic [31:0]   r_wdata;
    logic [31:0]   r_load;
    logic [31:0]   r_mem [0:(2**AW)-1];

    logic          w_req;
    logic          w_accept;
    logic          w_enter_done;
    logic          w_we;
    logic          w_mis;
    logic [AW-1:0] w_word;
    logic          w_unused_addr;

    assign w_req    = dREN | dWEN;
    assign w_accept = (r_state == IDLE) && w_req && !halt;

    // With LAT=0 the request goes straight to DONE, so the read uses the live inputs.
    assign w_word = (r_state == IDLE) ? dmemaddr[AW+1:2] : r_word;
    assign w_we   = (r_state == IDLE) ? dWEN : r_we;
    assign w_mis  = (r_state == IDLE) ? (dmemaddr[1:0] != 2'b00) : r_mis;

    assign w_enter_done = (w_accept && (LAT == 0)) ||
                          ((r_state == BUSY) && w_req && (r_cnt == 4'd1));

    assign w_unused_addr = ^dmemaddr[31:AW+2];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_word  <= '0;
            r_wdata <= 32'd0;
            r_load  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= dWEN;
                        r_mis   <= (dmemaddr[1:0] != 2'b00);
                        r_word  <= dmemaddr[AW+1:2];
                        r_wdata <= dmemstore;
                        r_cnt   <= 4'(LAT);
                        r_state <= (LAT == 0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (!w_req) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_enter_done && !w_we && !w_mis) begin
                r_load <= r_mem[w_word];
            end
        end
    end

    // The write commits at the end of the dhit cycle, so any later read sees it.
    always_ff @(posedge CLK) begin
        if ((r_state == DONE) && r_we && !r_mis) begin
            r_mem[r_word] <= r_wdata;
        end
    end

    assign dhit     = (r_state == DONE);
    assign derr     = (r_state == DONE) && r_mis;
    assign dmemload = r_load;

`ifdef DMEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else if ((r_state == DONE) && !r_mis) begin
            if (r_we) begin
                if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            end else begin
                if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = 16'd0;
    assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LAT=2 and LAT=0
module tb_dmem_responder;
    localparam int AW    = 10;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST      [2];
    logic        dREN      [2];
    logic        dWEN      [2];
    logic        halt      [2];
    logic        dhit      [2];
    logic        derr      [2];
    logic [31:0] dmemaddr  [2];
    logic [31:0] dmemstore [2];
    logic [31:0] dmemload  [2];
    logic [15:0] rd_count  [2];
    logic [15:0] wr_count  [2];

    logic [31:0] model     [2][1024];
    logic [31:0] last_load [2];
    int          exp_rd    [2];
    int          exp_wr    [2];
    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    always #5 CLK = ~CLK;

    dmem_responder #(.LAT(LAT_A), .AW(AW)) u_dut_a (
        .CLK(CLK), .nRST(nRST[0]), .dREN(dREN[0]), .dWEN(dWEN[0]),
        .dmemaddr(dmemaddr[0]), .dmemstore(dmemstore[0]), .halt(halt[0]),
        .dhit(dhit[0]), .dmemload(dmemload[0]), .derr(derr[0]),
        .rd_count(rd_count[0]), .wr_count(wr_count[0])
    );

    dmem_responder #(.LAT(LAT_B), .AW(AW)) u_dut_b (
        .CLK(CLK), .nRST(nRST[1]), .dREN(dREN[1]), .dWEN(dWEN[1]),
        .dmemaddr(dmemaddr[1]), .dmemstore(dmemstore[1]), .halt(halt[1]),
        .dhit(dhit[1]), .dmemload(dmemload[1]), .derr(derr[1]),
        .rd_count(rd_count[1]), .wr_count(wr_count[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic start(input int d, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int   idx;
        logic mis;
        mis = (addr[1:0] != 2'b00);
        idx = int'((addr >> 2) & 32'h3FF);
        if (!mis) begin
            if (wen) begin
                model[d][idx] = data;
                exp_wr[d]++;
            end else begin
                last_load[d] = model[d][idx];
                exp_rd[d]++;
            end
        end
        e.data = last_load[d];
        e.err  = mis;
        sb.push_back(e);
        @(negedge CLK);
        dREN[d]      = ren;
        dWEN[d]      = wen;
        dmemaddr[d]  = addr;
        dmemstore[d] = data;
    endtask

    task automatic finish(input int d, input bit scramble);
        int   k;
        exp_t e;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
            if (scramble && k == 1 && !dhit[d]) begin
                dmemaddr[d]  = ~dmemaddr[d];
                dmemstore[d] = ~dmemstore[d];
            end
        end while (!dhit[d] && k < 20);
        check("latency", 32'(k), 32'(lat_of(d) + 1));
        e = sb.pop_front();
        check("dmemload", dmemload[d], e.data);
        check("derr", 32'(derr[d]), 32'(e.err));
        dREN[d] = 1'b0;
        dWEN[d] = 1'b0;
        @(negedge CLK);
        check("dhit_one_cycle", 32'(dhit[d]), 32'd0);
    endtask

    task automatic req(input int d, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data);
        start(d, ren, wen, addr, data);
        finish(d, 1'b0);
    endtask

    initial begin
        bit seen;
        for (int d = 0; d < 2; d++) begin
            nRST[d] = 1'b0; dREN[d] = 1'b0; dWEN[d] = 1'b0; halt[d] = 1'b0;
            dmemaddr[d] = 32'd0; dmemstore[d] = 32'd0;
            last_load[d] = 32'd0; exp_rd[d] = 0; exp_wr[d] = 0;
        end
        repeat (3) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check("rst_dhit", 32'(dhit[d]), 32'd0);
            check("rst_dmemload", dmemload[d], 32'd0);
            check("rst_derr", 32'(derr[d]), 32'd0);
            check("rst_rd_count", 32'(rd_count[d]), 32'd0);
            check("rst_wr_count", 32'(wr_count[d]), 32'd0);
        end
        nRST[0] = 1'b1;
        nRST[1] = 1'b1;
        @(negedge CLK);

        // Write with address/data disturbed during BUSY, then read back
        start(0, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        finish(0, 1'b1);
        req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);

        req(0, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678);
        req(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);

        req(0, 1'b1, 1'b0, 32'h0000_0042, 32'h0);
        req(0, 1'b0, 1'b1, 32'h0000_0042, 32'hFFFF_FFFF);
        req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);

        // Abort: write dropped during BUSY
        @(negedge CLK);
        dWEN[0] = 1'b1; dmemaddr[0] = 32'h40; dmemstore[0] = 32'h1111_1111;
        @(negedge CLK);
        dWEN[0] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (dhit[0]) seen = 1'b1;
        end
        check("abort_no_dhit", 32'(seen), 32'd0);
        req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);

        // Reset during BUSY of a write
        @(negedge CLK);
        dWEN[0] = 1'b1; dmemaddr[0] = 32'h40; dmemstore[0] = 32'h0BAD_0BAD;
        @(negedge CLK);
        nRST[0] = 1'b0;
        dWEN[0] = 1'b0;
        @(negedge CLK);
        nRST[0] = 1'b1;
        last_load[0] = 32'd0; exp_rd[0] = 0; exp_wr[0] = 0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (dhit[0]) seen = 1'b1;
        end
        check("reset_no_dhit", 32'(seen), 32'd0);
        check("reset_dmemload", dmemload[0], 32'd0);
        req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);

        req(0, 1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
        req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);

        // halt holds off acceptance while asserted
        halt[0] = 1'b1;
        start(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (dhit[0]) seen = 1'b1;
        end
        check("halt_no_dhit", 32'(seen), 32'd0);
        halt[0] = 1'b0;
        finish(0, 1'b0);

        req(0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004);

`ifdef DMEM_STATS_EN
        check("rd_count", 32'(rd_count[0]), 32'(exp_rd[0]));
        check("wr_count", 32'(wr_count[0]), 32'(exp_wr[0]));
`else
        check("rd_count", 32'(rd_count[0]), 32'd0);
        check("wr_count", 32'(wr_count[0]), 32'd0);
`endif

        // Zero-latency instance
        req(1, 1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
        req(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        req(1, 1'b1, 1'b0, 32'h0000_0012, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
